// File: rtl/display_pkg.sv
// Shared definitions for the display arbiter.
// Holds the requester count, data width, FSM state encoding,
// hold-counter width and small index/slice helpers.
package display_pkg;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 12;
  localparam int CNT_W   = 16;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OPEN = 2'd2
  } state_t;

  // One-hot grant vector for a requester index.
  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] base;
    base = 4'b0001;
    return base << idx;
  endfunction

  // Select one requester's value out of the packed data bus.
  function automatic logic [DATA_W-1:0] data_slice(
    input logic [NUM_REQ*DATA_W-1:0] bus,
    input logic [IDX_W-1:0]          idx
  );
    logic [DATA_W-1:0] val;
    case (idx)
      2'd0:    val = bus[11:0];
      2'd1:    val = bus[23:12];
      2'd2:    val = bus[35:24];
      2'd3:    val = bus[47:36];
      default: val = 12'h000;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   mask   - candidate request bits
//   start  - index where the search begins (wraps modulo NUM_REQ)
//   found  - high when any mask bit is set
//   winner - first set index at or after start
module rr_pick
  import display_pkg::*;
(
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W-1:0] cand_s;

  // Walk the indices from start; the first set bit locks the winner.
  always_comb begin
    found  = 1'b0;
    winner = start;
    cand_s = start;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = start + IDX_W'(i);
      winner = (!found && mask[cand_s]) ? cand_s : winner;
      found  = found | mask[cand_s];
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter choosing which requester drives the hex display.
// A grant is held for at least HOLD_CYCLES cycles (HOLD), then stays open
// until another requester asks (OPEN). Dropping the granted request
// re-arbitrates immediately.
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   req        - per-requester level requests
//   req_data   - 12-bit value per requester, packed
//   gnt        - one-hot grant (zero when idle), registered
//   disp_data  - granted requester's value, registered
//   disp_src   - granted requester index, registered
//   disp_valid - high while a grant is held, registered
module display_arbiter
  import display_pkg::*;
#(
  parameter logic [CNT_W-1:0] HOLD_CYCLES = 16'd50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         disp_data,
  output logic [IDX_W-1:0]          disp_src,
  output logic                      disp_valid
);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [IDX_W-1:0] last_r, last_s;
  logic [IDX_W-1:0] idx_s;

  logic [NUM_REQ-1:0] mask_s;
  logic [IDX_W-1:0]   start_s;
  logic               found_s;
  logic [IDX_W-1:0]   win_s;
  logic               held_s;

  // The current holder is excluded from the search; when it has dropped its
  // bit is already low, so one mask serves IDLE, drop and OPEN alike.
  assign mask_s  = req & ~gnt;
  assign start_s = last_r + 2'd1;
  assign held_s  = req[disp_src];

  rr_pick u_pick (
    .mask   (mask_s),
    .start  (start_s),
    .found  (found_s),
    .winner (win_s)
  );

  // Next-state logic: grant, hold countdown, open release and drop handling.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    last_s  = last_r;
    idx_s   = disp_src;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s = HOLD;
          cnt_s   = HOLD_CYCLES - 16'd1;
          last_s  = win_s;
          idx_s   = win_s;
        end else begin
          state_s = IDLE;
        end
      end
      HOLD: begin
        // A drop wins over expiry in the same cycle.
        if (!held_s) begin
          if (found_s) begin
            state_s = HOLD;
            cnt_s   = HOLD_CYCLES - 16'd1;
            last_s  = win_s;
            idx_s   = win_s;
          end else begin
            state_s = IDLE;
          end
        end else if (cnt_r == 16'd0) begin
          state_s = OPEN;
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
      OPEN: begin
        if (found_s) begin
          state_s = HOLD;
          cnt_s   = HOLD_CYCLES - 16'd1;
          last_s  = win_s;
          idx_s   = win_s;
        end else if (!held_s) begin
          state_s = IDLE;
        end else begin
          state_s = OPEN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counter and registered display outputs, all on one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 16'd0;
      last_r     <= 2'd3;
      gnt        <= 4'b0000;
      disp_data  <= 12'h000;
      disp_src   <= 2'd0;
      disp_valid <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      last_r  <= last_s;
      if (state_s != IDLE) begin
        gnt        <= idx_onehot(idx_s);
        disp_data  <= data_slice(req_data, idx_s);
        disp_src   <= idx_s;
        disp_valid <= 1'b1;
      end else begin
        gnt        <= 4'b0000;
        disp_data  <= 12'h000;
        disp_src   <= 2'd0;
        disp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: one instance with HOLD_CYCLES = 4,
// one with HOLD_CYCLES = 1. Inputs change and outputs are checked on the
// falling edge.
module tb_display_arbiter;

  logic        clk;
  logic        rst, rst1;
  logic [3:0]  req, req1;
  logic [47:0] rd, rd1;
  logic [3:0]  gnt, gnt1;
  logic [11:0] dd, dd1;
  logic [1:0]  src, src1;
  logic        vld, vld1;

  int total = 0;
  int bad   = 0;

  display_arbiter #(.HOLD_CYCLES(16'd4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(rd),
    .gnt(gnt), .disp_data(dd), .disp_src(src), .disp_valid(vld)
  );

  display_arbiter #(.HOLD_CYCLES(16'd1)) dut1 (
    .clk(clk), .rst(rst1), .req(req1), .req_data(rd1),
    .gnt(gnt1), .disp_data(dd1), .disp_src(src1), .disp_valid(vld1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    rst1 = 1'b1;
    req  = 4'b0000;
    req1 = 4'b0000;
    rd   = {12'hD44, 12'hC33, 12'hB22, 12'hA11};
    rd1  = {12'h444, 12'h333, 12'h222, 12'h111};
    tick();
    tick();

    // Reset state
    chk("rst_gnt",  {12'h0, gnt}, 16'h0000);
    chk("rst_data", {4'h0, dd},   16'h0000);
    chk("rst_src",  {14'h0, src}, 16'h0000);
    chk("rst_vld",  {15'h0, vld}, 16'h0000);

    // First grant after release goes to requester 0
    req = 4'b0101;
    rst = 1'b0;
    tick();
    chk("first_gnt",  {12'h0, gnt}, 16'h0001);
    chk("first_src",  {14'h0, src}, 16'h0000);
    chk("first_vld",  {15'h0, vld}, 16'h0001);
    chk("first_data", {4'h0, dd},   16'h0A11);

    // Rotation: 4 HOLD cycles + 1 OPEN cycle, then switch
    req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rot_hold0", {12'h0, gnt}, 16'h0001);
    end
    tick();
    chk("rot_to1_gnt",  {12'h0, gnt}, 16'h0002);
    chk("rot_to1_src",  {14'h0, src}, 16'h0001);
    chk("rot_to1_data", {4'h0, dd},   16'h0B22);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rot_hold1", {12'h0, gnt}, 16'h0002);
    end
    tick();
    chk("rot_back0", {12'h0, gnt}, 16'h0001);

    // Everyone drops during HOLD -> idle
    req = 4'b0000;
    tick();
    chk("idle_gnt", {12'h0, gnt}, 16'h0000);
    chk("idle_vld", {15'h0, vld}, 16'h0000);

    // Requester 2 granted, drops at HOLD cycle 1 while 3 requests
    req = 4'b0100;
    tick();
    chk("g2_gnt", {12'h0, gnt}, 16'h0004);
    req = 4'b1000;
    tick();
    chk("drop_gnt",  {12'h0, gnt}, 16'h0008);
    chk("drop_src",  {14'h0, src}, 16'h0003);
    chk("drop_data", {4'h0, dd},   16'h0D44);
    // Reloaded counter: 4 more cycles on requester 3 despite requester 0
    req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("reload_hold3", {12'h0, gnt}, 16'h0008);
    end
    tick();
    chk("after3_gnt", {12'h0, gnt}, 16'h0001);

    // Expiry coincides with drop, nothing else pending -> idle
    req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("exp_hold0", {12'h0, gnt}, 16'h0001);
    end
    req = 4'b0000;
    tick();
    chk("expdrop_gnt",  {12'h0, gnt}, 16'h0000);
    chk("expdrop_vld",  {15'h0, vld}, 16'h0000);
    chk("expdrop_data", {4'h0, dd},   16'h0000);

    // Live data tracking for sole requester 1 in OPEN
    rd[23:12] = 12'hABC;
    req = 4'b0010;
    tick();
    chk("live_gnt",  {12'h0, gnt}, 16'h0002);
    chk("live_data", {4'h0, dd},   16'h0ABC);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("live_open", {12'h0, gnt}, 16'h0002);
    end
    rd[23:12] = 12'h123;
    chk("live_lag", {4'h0, dd}, 16'h0ABC);
    tick();
    chk("live_new",  {4'h0, dd},   16'h0123);
    chk("live_gnt2", {12'h0, gnt}, 16'h0002);

    // HOLD_CYCLES = 1 instance
    req1 = 4'b1010;
    rst1 = 1'b0;
    tick();
    chk("h1_first", {12'h0, gnt1}, 16'h0002);
    tick();
    chk("h1_open", {12'h0, gnt1}, 16'h0002);
    tick();
    chk("h1_switch",  {12'h0, gnt1}, 16'h0008);
    chk("h1_data",    {4'h0, dd1},   16'h0444);
    // Asynchronous reset mid-HOLD
    rst1 = 1'b1;
    #1;
    chk("h1_arst_gnt",  {12'h0, gnt1}, 16'h0000);
    chk("h1_arst_vld",  {15'h0, vld1}, 16'h0000);
    chk("h1_arst_data", {4'h0, dd1},   16'h0000);
    chk("h1_arst_src",  {14'h0, src1}, 16'h0000);
    tick();
    req1 = 4'b0110;
    rst1 = 1'b0;
    tick();
    chk("h1_relgnt", {12'h0, gnt1}, 16'h0002);
    chk("h1_relsrc", {14'h0, src1}, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
